// File: rtl/cla_serial_ctrl.sv
// Nibble-serial add/subtract sequencer driving one 4-bit carry-lookahead datapath.
// Operands are consumed LS nibble first; the carry is chained between nibbles in carry_q.
module cla_serial_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic                   cin,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  output logic                   ready,
  output logic [3:0]             dp_a,
  output logic [3:0]             dp_b,
  output logic                   dp_cin,
  input  logic [4:0]             dp_q,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   overflow
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [W-1:0]       a_sh_q, a_sh_d;
  logic [W-1:0]       b_sh_q, b_sh_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = op_a;
          b_sh_d  = sub ? ~op_b : op_b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // New nibble enters at the top; after NIBBLES shifts the word is fully replaced.
        sum_d   = W'({dp_q[3:0], sum_q} >> 4);
        carry_d = dp_q[4];
        a_sh_d  = a_sh_q >> 4;
        b_sh_d  = b_sh_q >> 4;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NIBBLES - 1)) begin
          cout_d  = dp_q[4];
          // Overflow is carry-out of bit 3 xor carry-in to bit 3 of the top nibble.
          ovf_d   = dp_q[4] ^ (dp_q[3] ^ a_sh_q[3] ^ b_sh_q[3]);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready  = (state_q == IDLE);
    done   = (state_q == DONE);
    dp_a   = 4'h0;
    dp_b   = 4'h0;
    dp_cin = 1'b0;
    if (state_q == RUN) begin
      dp_a   = a_sh_q[3:0];
      dp_b   = b_sh_q[3:0];
      dp_cin = carry_q;
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_cla_serial_ctrl.sv
// Directed bench for cla_serial_ctrl with NIBBLES=4; a behavioral 4-bit adder stands in for the datapath.
module tb_cla_serial_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         ready;
  logic [3:0]   dp_a;
  logic [3:0]   dp_b;
  logic         dp_cin;
  logic [4:0]   dp_q;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign dp_q = {1'b0, dp_a} + {1'b0, dp_b} + {4'b0, dp_cin};

  cla_serial_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin),
    .op_a(op_a), .op_b(op_b), .ready(ready), .dp_a(dp_a), .dp_b(dp_b),
    .dp_cin(dp_cin), .dp_q(dp_q), .done(done), .sum(sum), .cout(cout),
    .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge after the done cycle.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic c, input logic [W-1:0] es,
                        input logic ec, input logic eo, input logic [15:0] edpa);
    logic [15:0] seen;
    int          lat;
    seen = '0;
    lat  = 0;
    chk({tag, "_ready_pre"}, 32'(ready), 32'd1);
    op_a = a; op_b = b; sub = s; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cyc <= N) seen = {dp_a, seen[15:4]};
      if (done) begin lat = cyc; break; end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(N + 1));
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
    if (edpa != 16'h0) chk({tag, "_dpa_seq"}, 32'(seen), 32'(edpa));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_ready_post"}, 32'(ready), 32'd1);
  endtask

  initial begin : main
    int ndone;
    int d1;
    int d2;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_dpa", 32'(dp_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 16'h1234);
    run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0);
    run_op("povf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 16'h0);
    run_op("cin", 16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0);
    run_op("sub", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 16'h0);
    run_op("subovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 16'h0);

    // Asynchronous reset mid-cycle clears outputs immediately.
    run_op("pre_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 16'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(ready), 32'd1);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_sum", 32'(sum), 32'd0);
    chk("arst_cout", 32'(cout), 32'd0);
    chk("arst_dp", 32'({dp_a, dp_b, 3'b0, dp_cin}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Busy ignore: a second start during RUN must not disturb the running op.
    op_a = 16'h1234; op_b = 16'h0FFF; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(negedge clk);
      if (cyc == 2) begin
        op_a = 16'hFFFF; op_b = 16'hAAAA; sub = 1'b1; start = 1'b1;
        chk("busy_ready", 32'(ready), 32'd0);
      end
      if (cyc == 3) start = 1'b0;
      if (done) begin
        ndone++;
        chk("busy_sum", 32'(sum), 32'h2233);
      end
    end
    chk("busy_ndone", 32'(ndone), 32'd1);

    // Held start: back-to-back operations at N+2 spacing.
    op_a = 16'h0100; op_b = 16'h0200; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    d1 = 0; d2 = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cyc == 2 * N) start = 1'b0;
      if (done && d1 == 0) begin
        d1 = cyc;
        chk("held_sum1", 32'(sum), 32'h0300);
        op_a = 16'h1111; op_b = 16'h2222;
      end else if (done && d2 == 0) begin
        d2 = cyc;
        chk("held_sum2", 32'(sum), 32'h3333);
      end
    end
    chk("held_d1", 32'(d1), 32'(N + 1));
    chk("held_spacing", 32'(d2 - d1), 32'(N + 2));

    // Reset during the second RUN cycle aborts without done.
    op_a = 16'h4444; op_b = 16'h1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    ndone = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_ndone", 32'(ndone), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("fresh", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
